// File: rtl/uart_autobaud.sv
// UART auto-baud calibrator: measures a 0x55 sync character on rxd, derives the
// receiver prescale (bit time = 8*prescale clk) and supervises the lock afterwards.
module uart_autobaud #(
    parameter int unsigned IDLE_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH   = 24,
    parameter int unsigned ERR_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        recal,
    input  logic        rxd,
    input  logic        rx_frame_error,
    input  logic        rx_byte_valid,
    output logic [15:0] prescale,
    output logic        rx_hold,
    output logic        locked,
    output logic        cal_busy,
    output logic        cal_fail
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int unsigned T8_W   = CNT_WIDTH + 2;
    localparam int unsigned P_W    = (CNT_WIDTH + 3 > 17) ? CNT_WIDTH + 3 : 17;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_WAIT_STOP,
        S_LOCKED
    } state_e;

    state_e                 state_q, state_d;
    logic                   rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   i1_q, i1_d;
    logic [T8_W-1:0]        t8_q, t8_d;
    logic [2:0]             edge_idx_q, edge_idx_d;
    logic                   stop_high_q, stop_high_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
    logic [15:0]            p_q, p_d;
    logic [15:0]            prescale_q, prescale_d;
    logic                   locked_q, locked_d;
    logic                   rx_hold_q, rx_hold_d;
    logic                   cal_busy_q, cal_busy_d;
    logic                   cal_fail_q, cal_fail_d;

    logic                   fall_edge, rise_edge;
    logic [CNT_WIDTH-1:0]   diff, tol;
    logic [T8_W-1:0]        t8_sum;
    logic [P_W-1:0]         p_new;
    logic                   p_ok;
    logic                   attempt_fail;

    // Edge detection on the synchronized line only
    assign fall_edge = rxd_prev_q & ~rxd_sync_q;
    assign rise_edge = ~rxd_prev_q & rxd_sync_q;

    assign diff   = (cnt_q >= i1_q) ? (cnt_q - i1_q) : (i1_q - cnt_q);
    assign tol    = i1_q >> 2;
    assign t8_sum = t8_q + T8_W'(cnt_q);
    assign p_new  = (P_W'(t8_sum) + P_W'(32)) >> 6;
    assign p_ok   = (p_new != '0) && (p_new <= P_W'(16'hFFFF));

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = '0;
        cnt_d        = cnt_q;
        i1_d         = i1_q;
        t8_d         = t8_q;
        edge_idx_d   = edge_idx_q;
        stop_high_d  = stop_high_q;
        err_cnt_d    = '0;
        p_d          = p_q;
        prescale_d   = prescale_q;
        attempt_fail = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT_IDLE;

                S_WAIT_IDLE: begin
                    if (rxd_sync_q) begin
                        if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) state_d = S_WAIT_START;
                        else idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end

                S_WAIT_START: begin
                    if (fall_edge) begin
                        state_d    = S_MEASURE;
                        cnt_d      = CNT_WIDTH'(1);
                        edge_idx_d = '0;
                    end
                end

                // cnt_q equals the cycles elapsed since the previous falling edge
                S_MEASURE: begin
                    if (cnt_q == CNT_MAX) begin
                        attempt_fail = 1'b1;
                    end else if (fall_edge) begin
                        cnt_d = CNT_WIDTH'(1);
                        if (edge_idx_q == 3'd0) begin
                            i1_d       = cnt_q;
                            t8_d       = T8_W'(cnt_q);
                            edge_idx_d = 3'd1;
                        end else if (diff > tol) begin
                            attempt_fail = 1'b1;
                        end else begin
                            t8_d       = t8_sum;
                            edge_idx_d = edge_idx_q + 3'd1;
                            if (edge_idx_q == 3'd3) begin
                                if (p_ok) begin
                                    p_d         = p_new[15:0];
                                    stop_high_d = 1'b0;
                                    state_d     = S_WAIT_STOP;
                                end else begin
                                    attempt_fail = 1'b1;
                                end
                            end
                        end
                    end else if (edge_idx_q != 3'd0 && cnt_q > i1_q && diff > tol) begin
                        // Interval already beyond tolerance; its edge can only fail
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end

                S_WAIT_STOP: begin
                    if (!stop_high_q) begin
                        if (rise_edge) begin
                            stop_high_d = 1'b1;
                            cnt_d       = CNT_WIDTH'(1);
                        end else if (cnt_q >= i1_q) begin
                            attempt_fail = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        if (!rxd_sync_q) begin
                            attempt_fail = 1'b1;
                        end else if (cnt_q >= tol) begin
                            prescale_d = p_q;
                            state_d    = S_LOCKED;
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end

                S_LOCKED: begin
                    if (recal) begin
                        state_d = S_WAIT_IDLE;
                    end else if (rx_byte_valid) begin
                        err_cnt_d = '0;
                    end else if (rx_frame_error) begin
                        if (err_cnt_q == ERR_W'(ERR_LIMIT - 1)) state_d = S_WAIT_IDLE;
                        else err_cnt_d = err_cnt_q + ERR_W'(1);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end

                default: state_d = S_IDLE;
            endcase

            if (attempt_fail) state_d = S_WAIT_IDLE;
        end

        cal_fail_d = attempt_fail;
        locked_d   = (state_d == S_LOCKED);
        rx_hold_d  = (state_d != S_LOCKED);
        cal_busy_d = (state_d == S_WAIT_IDLE) || (state_d == S_WAIT_START) ||
                     (state_d == S_MEASURE)   || (state_d == S_WAIT_STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            idle_cnt_q  <= '0;
            cnt_q       <= '0;
            i1_q        <= '0;
            t8_q        <= '0;
            edge_idx_q  <= '0;
            stop_high_q <= 1'b0;
            err_cnt_q   <= '0;
            p_q         <= '0;
            prescale_q  <= '0;
            locked_q    <= 1'b0;
            rx_hold_q   <= 1'b1;
            cal_busy_q  <= 1'b0;
            cal_fail_q  <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_sync_q  <= rxd_meta_q;
            rxd_prev_q  <= rxd_sync_q;
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            cnt_q       <= cnt_d;
            i1_q        <= i1_d;
            t8_q        <= t8_d;
            edge_idx_q  <= edge_idx_d;
            stop_high_q <= stop_high_d;
            err_cnt_q   <= err_cnt_d;
            p_q         <= p_d;
            prescale_q  <= prescale_d;
            locked_q    <= locked_d;
            rx_hold_q   <= rx_hold_d;
            cal_busy_q  <= cal_busy_d;
            cal_fail_q  <= cal_fail_d;
        end
    end

    assign prescale = prescale_q;
    assign rx_hold  = rx_hold_q;
    assign locked   = locked_q;
    assign cal_busy = cal_busy_q;
    assign cal_fail = cal_fail_q;

endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 Parameter IDLE_CYCLES, default 1024: consecutive high rxd cycles required before a sync character is accepted.
REQ-002 Parameter CNT_WIDTH, default 24: width of the interval and timeout counters.
REQ-003 Parameter ERR_LIMIT, default 4: consecutive frame errors while locked that force recalibration.
REQ-004 clk  input  1  rising-edge clock; the block uses one clock and is synchronous to clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  level; 1 runs calibration and lock monitoring, 0 idles the block.
REQ-007 recal  input  1  single-cycle pulse requesting a new calibration.
REQ-008 rxd  input  1  raw asynchronous UART line, shared with the receiver.
REQ-009 rx_frame_error  input  1  single-cycle frame-error pulse from the receiver.
REQ-010 rx_byte_valid  input  1  single-cycle pulse on each accepted received byte (tvalid and tready).
REQ-011 prescale  output  16  receiver prescale value, where one bit time equals 8*prescale clk cycles.
REQ-012 rx_hold  output  1  1 holds the receiver in reset.
REQ-013 locked  output  1  1 means prescale is valid and the receiver is running.
REQ-014 cal_busy  output  1  1 while in WAIT_IDLE, WAIT_START, MEASURE or WAIT_STOP.
REQ-015 cal_fail  output  1  single-cycle pulse on any rejected calibration attempt.

Function
REQ-016 rxd SHALL pass through a 2-flop synchronizer whose flops reset to 1; all edge detection SHALL use the synchronized signal.
REQ-017 States SHALL be IDLE, WAIT_IDLE, WAIT_START, MEASURE, WAIT_STOP and LOCKED.
REQ-018 When enable=0, the next state SHALL be IDLE from any state; prescale SHALL be retained; locked=0 and rx_hold=1.
REQ-019 IDLE SHALL move to WAIT_IDLE when enable=1.
REQ-020 WAIT_IDLE: a high-cycle counter SHALL increment on each high cycle and clear on each low cycle; reaching IDLE_CYCLES SHALL move to WAIT_START.
REQ-021 WAIT_START: the first falling edge (F0) SHALL move to MEASURE and clear the interval counter.
REQ-022 The sync character SHALL be 0x55 (8N1, LSB first), giving falling edges F0..F4 two bit times apart.
REQ-023 MEASURE SHALL record intervals I1..I4 in clk cycles between successive falling edges, and T8=I1+I2+I3+I4.
REQ-024 MEASURE SHALL fail if, for any k, |Ik-I1| > I1>>2, checked at each edge.
REQ-025 MEASURE SHALL fail if the interval counter reaches 2^CNT_WIDTH-1 (saturating; no wrap).
REQ-026 After F4, the state SHALL be WAIT_STOP, and P=(T8+32)>>6 SHALL be computed at full width without truncation before the range check.
REQ-027 The attempt SHALL fail if P=0 or P>65535.
REQ-028 WAIT_STOP: a rising edge SHALL occur within I1 cycles of F4, and the line SHALL then stay high for I1>>2 cycles; on success, prescale<=P and the state SHALL move to LOCKED.
REQ-029 Any failure SHALL pulse cal_fail for one cycle, SHALL leave prescale unchanged, and SHALL return the state to WAIT_IDLE.
REQ-030 LOCKED: locked=1 and rx_hold=0 (registered, updated on the cycle of state entry).
REQ-031 LOCKED: rx_frame_error SHALL increment err_cnt and rx_byte_valid SHALL clear it; if both occur in the same cycle, the clear SHALL win.
REQ-032 LOCKED: when err_cnt reaches ERR_LIMIT, the state SHALL move to WAIT_IDLE, locked=0, rx_hold=1, and err_cnt SHALL be cleared.
REQ-033 LOCKED: recal=1 SHALL move to WAIT_IDLE with locked=0 and rx_hold=1 on the next cycle; recal in any other state SHALL be ignored.
REQ-034 rx_hold SHALL be 1 in every state except LOCKED.
REQ-035 cal_busy SHALL equal (state is WAIT_IDLE, WAIT_START, MEASURE or WAIT_STOP).

Reset
REQ-036 On rst_n=0, the state SHALL be IDLE asynchronously, including mid-calibration; prescale=0, locked=0, rx_hold=1, cal_busy=0, cal_fail=0, synchronizer=1, all counters=0.
REQ-037 Reset release SHALL take effect on the first clk edge after rst_n=1; the block SHALL require no further initialization.

Verification
REQ-038 Bench SHALL cover: enable=1, line high 1024+ cycles, then 0x55 at 800 clk/bit -> prescale=100, locked=1, rx_hold=0, cal_fail never asserted.
REQ-039 Bench SHALL cover: 0x55 at 868 clk/bit -> T8=6944, prescale=109 (rounded).
REQ-040 Bench SHALL cover: 0x0F sent as the sync character -> tolerance failure, cal_fail pulse, state WAIT_IDLE, prescale keeps its previous value.
REQ-041 Bench SHALL cover: in LOCKED, 3 frame errors, 1 byte_valid, 3 frame errors -> remains locked; a 4th consecutive error -> locked=0, rx_hold=1.
REQ-042 Bench SHALL cover: 0x55 at 4 clk/bit (T8=32, P=1 after rounding, passes) and line stuck low after F0 -> counter saturates, cal_fail.
REQ-043 Bench SHALL cover: rst_n pulsed low during MEASURE -> outputs at reset values immediately; a fresh calibration afterwards succeeds.
